// File: rtl/fft_bf_sched_if.sv
// Bus between the radix-2 FFT butterfly scheduler and its environment
// (start/done handshake, butterfly-unit launch/complete, RAM/ROM addressing).
// The scheduler uses the master modport; the environment uses the slave modport.
interface fft_bf_sched_if #(
    parameter int LOG2N = 3
);
    logic             start;
    logic             busy;
    logic             done;
    logic             bf_go;
    logic             bf_done;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic [LOG2N-2:0] tw_addr;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic [LOG2N-1:0] stage;
    logic             err;

    modport master (
        input  start, bf_done,
        output busy, done, bf_go, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage, err
    );

    modport slave (
        output start, bf_done,
        input  busy, done, bf_go, rd_addr_a, rd_addr_b, tw_addr,
               wr_en, wr_addr_a, wr_addr_b, stage, err
    );
endinterface

// File: rtl/fft_bf_sched.sv
// In-place radix-2 FFT butterfly scheduler. Walks LOG2N stages of N/2
// butterflies, each as RD -> GO -> WAIT (for bf_done) -> WR, then pulses done.
// Optional feature: define FFT_SCHED_WDOG_EN to add a 4-bit WAIT watchdog that
// aborts the pass and sets a sticky err flag after 15 cycles without bf_done.
// With the macro undefined, WAIT is unbounded and err is tied low.
module fft_bf_sched #(
    parameter int LOG2N = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    fft_bf_sched_if.master bus
);

    localparam int                KW     = LOG2N - 1;
    localparam int                HALF   = 1 << KW;
    localparam logic [KW-1:0]     K_LAST = KW'(HALF - 1);
    localparam logic [LOG2N-1:0]  S_LAST = LOG2N'(LOG2N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GO,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [LOG2N-1:0] a;
        logic [LOG2N-1:0] b;
        logic [KW-1:0]    tw;
    } bf_addr_t;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [KW-1:0]    k_q, k_d;
    bf_addr_t         addr_q, addr_next;
    logic             load;
    logic             last_bf;
    logic             busy, done, bf_go, wr_en;

    // Leg addresses: insert a 0 bit at position s of k (upper leg), set it for
    // the lower leg; twiddle index is the in-group position scaled to N/2.
    function automatic bf_addr_t calc_addr(input logic [LOG2N-1:0] s,
                                           input logic [KW-1:0]    k);
        bf_addr_t         r;
        logic [LOG2N-1:0] hi_mask;
        logic [LOG2N-1:0] kx;
        logic [LOG2N-1:0] lo;
        logic [LOG2N-1:0] hi;
        logic [LOG2N-1:0] sh;
        hi_mask = {LOG2N{1'b1}} << s;
        kx      = {1'b0, k};
        lo      = kx & ~hi_mask;
        hi      = kx & hi_mask;
        sh      = S_LAST - s;
        r.a     = (hi << 1) | lo;
        r.b     = r.a | (LOG2N'(1) << s);
        r.tw    = KW'(lo << sh);
        return r;
    endfunction

    assign last_bf = (k_q == K_LAST) && (stage_q == S_LAST);

`ifdef FFT_SCHED_WDOG_EN
    logic [3:0] wdog_q, wdog_d;
    logic       err_q, err_d;
    logic       timeout;

    // Fires on the 15th consecutive WAIT cycle that sees no bf_done.
    assign timeout = (state_q == ST_WAIT) && !bus.bf_done && (wdog_q == 4'd14);

    // Watchdog and sticky error next-state.
    always_comb begin
        wdog_d = 4'd0;
        err_d  = err_q;
        if ((state_q == ST_WAIT) && !bus.bf_done) begin
            wdog_d = wdog_q + 4'd1;
        end
        if ((state_q == ST_IDLE) && bus.start) begin
            err_d = 1'b0;
        end else if (timeout) begin
            err_d = 1'b1;
        end
    end

    // Watchdog and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_RD;
            ST_RD:   state_d = ST_GO;
            ST_GO:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (bus.bf_done) begin
                    state_d = ST_WR;
                end
`ifdef FFT_SCHED_WDOG_EN
                else if (timeout) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_WR:   state_d = last_bf ? ST_DONE : ST_RD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the current state only.
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        bf_go = 1'b0;
        wr_en = 1'b0;
        case (state_q)
            ST_IDLE: busy  = 1'b0;
            ST_GO:   bf_go = 1'b1;
            ST_WR:   wr_en = 1'b1;
            ST_DONE: done  = 1'b1;
            default: busy  = 1'b0;
        endcase
        busy = (state_q != ST_IDLE);
    end

    // Butterfly counter: restart on accepted start, advance after each write.
    always_comb begin
        stage_d = stage_q;
        k_d     = k_q;
        load    = 1'b0;
        if ((state_q == ST_IDLE) && bus.start) begin
            stage_d = '0;
            k_d     = '0;
            load    = 1'b1;
        end else if ((state_q == ST_WR) && !last_bf) begin
            load = 1'b1;
            if (k_q == K_LAST) begin
                k_d     = '0;
                stage_d = stage_q + LOG2N'(1);
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    assign addr_next = calc_addr(stage_d, k_d);

    // Counter and address registers; addresses are captured on entry to RD
    // and held through WR so read and write-back share the same pair.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these registers drive outputs that must read 0 in reset, so
        // they take the async reset rather than being left uninitialised.
        if (!rst_n) begin
            stage_q <= '0;
            k_q     <= '0;
            addr_q  <= '0;
        end else begin
            stage_q <= stage_d;
            k_q     <= k_d;
            if (load) begin
                addr_q <= addr_next;
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.bf_go     = bf_go;
    assign bus.wr_en     = wr_en;
    assign bus.rd_addr_a = addr_q.a;
    assign bus.rd_addr_b = addr_q.b;
    assign bus.tw_addr   = addr_q.tw;
    assign bus.wr_addr_a = addr_q.a;
    assign bus.wr_addr_b = addr_q.b;
    assign bus.stage     = stage_q;

endmodule

// File: doc/fft_bf_sched.md
FFT_BF_SCHED -- requirements
Module: fft_bf_sched

Interface
REQ-001 Parameter LOG2N, default 3, log2 of FFT length N (N=2^LOG2N, N/2 butterflies per stage, LOG2N stages).
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one full in-place radix-2 FFT pass.
REQ-005 busy  output  1  high from first cycle after accepted start until the DONE cycle inclusive.
REQ-006 done  output  1  one-cycle pulse on completion.
REQ-007 bf_go  output  1  one-cycle launch pulse to the butterfly unit.
REQ-008 bf_done  input  1  one-cycle completion pulse from the butterfly unit.
REQ-009 rd_addr_a, rd_addr_b  output  LOG2N each  data RAM read addresses (upper/lower leg).
REQ-010 tw_addr  output  LOG2N-1  twiddle ROM address.
REQ-011 wr_en  output  1  data RAM write strobe for both legs.
REQ-012 wr_addr_a, wr_addr_b  output  LOG2N each  write-back addresses.
REQ-013 stage  output  LOG2N bits wide  current stage index.
REQ-014 err  output  1  sticky watchdog error flag (see Configuration).

Function
REQ-015 FSM states IDLE, RD, GO, WAIT, WR, DONE; one cycle each except IDLE and WAIT.
REQ-016 IDLE: start=1 -> RD, stage=0, k=0 (butterfly index), err cleared; start ignored in all other states.
REQ-017 Addressing for stage s, index k: h=2^s, pos=k mod h, grp=k div h; addr_a=2·h·grp+pos, addr_b=addr_a+h, tw_addr=pos·2^(LOG2N-1-s), unsigned, modulo width.
REQ-018 RD: rd_addr_a/b and tw_addr valid (synchronous RAM/ROM, 1-cycle read latency) -> GO.
REQ-019 GO: bf_go=1 for exactly one cycle -> WAIT; addresses held stable RD through WR.
REQ-020 WAIT: holds until bf_done=1, then -> WR; bf_done in any other state ignored.
REQ-021 WR: wr_en=1 one cycle, wr_addr_a/b equal the RD addresses of the same butterfly.
REQ-022 After WR: k<N/2-1 -> k+1, RD; else if stage<LOG2N-1 -> stage+1, k=0, RD; else -> DONE.
REQ-023 DONE: done=1 one cycle -> IDLE; start in DONE cycle ignored.
REQ-024 With bf_done 4 cycles after bf_go, each butterfly takes 7 cycles; done asserts at cycle S+1+7·(N/2)·LOG2N, S = start-sample cycle (N=8: S+85).
REQ-025 bf_go, wr_en, done never asserted together; at most one bf_go outstanding.

Reset
REQ-026 rst_n low at any time, including mid-pass: state IDLE, stage=0, k=0, all address outputs 0, busy/done/bf_go/wr_en/err 0; pass abandoned, no write issued.
REQ-027 First start after rst_n release accepted normally.

Configuration
REQ-028 Macro FFT_SCHED_WDOG_EN defined: 4-bit watchdog counts WAIT cycles; 15 cycles without bf_done -> err=1 (sticky until next accepted start or reset), no wr_en, direct -> IDLE, no done pulse.
REQ-029 Macro FFT_SCHED_WDOG_EN undefined: WAIT unbounded, err tied 0, no watchdog logic.

Verification
REQ-030 LOG2N=3, model bf_done 4 cycles after bf_go, pulse start -> 12 bf_go pulses, 12 wr_en pulses, done exactly 85 cycles after start sample, busy high throughout.
REQ-031 Same run, log addresses -> stage0 pairs (0,1)(2,3)(4,5)(6,7) tw 0; stage1 (0,2)(1,3)(4,6)(5,7) tw 0,2,0,2; stage2 (0,4)(1,5)(2,6)(3,7) tw 0,1,2,3.
REQ-032 bf_done delayed to 9 cycles, plus spurious bf_done in IDLE and RD -> spurious pulses ignored, sequence unchanged, done at S+1+12·12=S+145.
REQ-033 Start re-pulsed while busy and in DONE cycle -> ignored, one pass only, one done.
REQ-034 rst_n low during stage 1 WAIT -> all outputs 0 immediately; new start yields full correct 85-cycle pass.
REQ-035 FFT_SCHED_WDOG_EN defined, bf_done withheld -> err=1 after 15 WAIT cycles, IDLE, no wr_en, no done; next start clears err.
